// File: rtl/ysyx_24110015_pkg.sv
// Shared definitions for the ysyx_24110015 NPC front end: RV32I opcode
// constants, the ebreak/nop encodings and the fetch/decode FSM states.
package ysyx_24110015_pkg;

  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_HALT  = 3'd4
  } fd_state_e;

endpackage

// File: rtl/ysyx_24110015_immgen.sv
// Combinational RV32I immediate generator: picks the immediate format from
// the opcode and returns the sign-extended 32-bit value (0 for formats
// that carry no immediate, e.g. R-type).
module ysyx_24110015_immgen
  import ysyx_24110015_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic [31:0] o_imm
);

  logic [6:0] w_opcode;

  assign w_opcode = i_inst[6:0];

  // Format select and sign extension from bit 31
  always_comb begin
    o_imm = 32'h0;
    case (w_opcode)
      OP_ALU_I, OP_LOAD, OP_JALR, OP_SYSTEM:
        o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      OP_STORE:
        o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      OP_BRANCH:
        o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        o_imm = {i_inst[31:12], 12'h000};
      OP_JAL:
        o_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      default:
        o_imm = 32'h0;
    endcase
  end

endmodule

// File: rtl/ysyx_24110015_fetch_decode.sv
// Multi-cycle fetch/decode front end. Owns the PC, fetches one instruction
// at a time over a valid/ready memory port, holds it in an instruction
// register and presents the decoded fields to the EXU until accepted.
module ysyx_24110015_fetch_decode
  import ysyx_24110015_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        ebreak,
  input  logic [31:0] pc_next,
  output logic        halted,
  output logic        misalign
);

  fd_state_e   r_state;
  fd_state_e   w_stateNext;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_misalign;

  logic        w_ebreak;
  logic        w_issueFire;
  logic        w_targetMisaligned;

  assign w_ebreak           = (r_inst == INST_EBREAK);
  assign w_issueFire        = (r_state == ST_ISSUE) && out_ready;
  assign w_targetMisaligned = (pc_next[1:0] != 2'b00);

  // Next-state selection; ebreak wins over a misaligned target on retire
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:  w_stateNext = ST_FETCH;
      ST_FETCH: if (imem_req_ready) w_stateNext = ST_WAIT;
      ST_WAIT:  if (imem_rsp_valid) w_stateNext = ST_ISSUE;
      ST_ISSUE: begin
        if (out_ready) begin
          if (w_ebreak || w_targetMisaligned) w_stateNext = ST_HALT;
          else                                w_stateNext = ST_FETCH;
        end
      end
      ST_HALT:  w_stateNext = ST_HALT;
      default:  w_stateNext = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_stateNext;
  end

  // Instruction register only captures a response while waiting for one,
  // so stray responses in IDLE/FETCH never reach decode
  always_ff @(posedge clk) begin
    if (rst)                                        r_inst <= INST_NOP;
    else if ((r_state == ST_WAIT) && imem_rsp_valid) r_inst <= imem_rsp_data;
  end

  // PC moves only on an accepted, non-halting retire; halts keep the old PC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else if (w_issueFire && !w_ebreak) begin
      if (w_targetMisaligned) r_misalign <= 1'b1;
      else                    r_pc       <= pc_next;
    end
  end

  ysyx_24110015_immgen u_immgen (
    .i_inst (r_inst),
    .o_imm  (imm)
  );

  assign imem_req_valid = (r_state == ST_FETCH);
  assign imem_addr      = r_pc;
  assign out_valid      = (r_state == ST_ISSUE);
  assign halted         = (r_state == ST_HALT);
  assign misalign       = r_misalign;
  assign pc             = r_pc;
  assign opcode         = r_inst[6:0];
  assign func3          = r_inst[14:12];
  assign func7          = r_inst[31:25];
  assign rs1            = r_inst[19:15];
  assign rs2            = r_inst[24:20];
  assign rd             = r_inst[11:7];
  assign ebreak         = w_ebreak;

endmodule

// File: tb/tb_ysyx_24110015_fetch_decode.sv
// Self-checking bench for the fetch/decode front end: directed fetch
// scenarios, a protocol-level model of the expected outputs, and literal
// spot checks on decoded fields.
module tb_ysyx_24110015_fetch_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        ebreak;
  logic [31:0] pc_next = 32'h0;
  logic        halted;
  logic        misalign;

  int checks = 0;
  int errors = 0;
  bit compareOn = 0;

  ysyx_24110015_fetch_decode #(.RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .pc             (pc),
    .opcode         (opcode),
    .func3          (func3),
    .func7          (func7),
    .rs1            (rs1),
    .rs2            (rs2),
    .rd             (rd),
    .imm            (imm),
    .ebreak         (ebreak),
    .pc_next        (pc_next),
    .halted         (halted),
    .misalign       (misalign)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Hard stop in case something stalls beyond every bounded wait
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h, expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Immediate derived from the RV32I format rules
  function automatic logic [31:0] refImm(input logic [31:0] inst);
    logic [6:0] op;
    op = inst[6:0];
    if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73)
      return {{20{inst[31]}}, inst[31:20]};
    else if (op == 7'h23)
      return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    else if (op == 7'h63)
      return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    else if (op == 7'h37 || op == 7'h17)
      return {inst[31:12], 12'h000};
    else if (op == 7'h6F)
      return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    return 32'h0;
  endfunction

  // Protocol-level model: tracks whether an instruction is outstanding at
  // memory, held for the EXU, or the core has stopped
  bit          mStarted;
  bit          mAwaiting;
  bit          mHolding;
  bit          mHalted;
  bit          mMisalign;
  logic [31:0] mPc;
  logic [31:0] mInst;

  always @(posedge clk) begin
    if (rst) begin
      mStarted  = 0;
      mAwaiting = 0;
      mHolding  = 0;
      mHalted   = 0;
      mMisalign = 0;
      mPc       = 32'h8000_0000;
      mInst     = 32'h0000_0013;
    end else if (!mStarted) begin
      mStarted = 1;
    end else if (!mHalted) begin
      if (mHolding) begin
        if (out_ready) begin
          mHolding = 0;
          if (mInst == 32'h0010_0073) mHalted = 1;
          else if (pc_next % 4 != 0) begin
            mHalted   = 1;
            mMisalign = 1;
          end else mPc = pc_next;
        end
      end else if (mAwaiting) begin
        if (imem_rsp_valid) begin
          mAwaiting = 0;
          mHolding  = 1;
          mInst     = imem_rsp_data;
        end
      end else if (imem_req_ready) begin
        mAwaiting = 1;
      end
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    if (compareOn) begin
      logic expReq, expValid;
      expReq   = mStarted && !mHalted && !mHolding && !mAwaiting;
      expValid = mStarted && !mHalted && mHolding;
      checkOutput("reqValid", {31'b0, imem_req_valid}, {31'b0, expReq});
      checkOutput("outValid", {31'b0, out_valid}, {31'b0, expValid});
      checkOutput("halted", {31'b0, halted}, {31'b0, mHalted});
      checkOutput("misalign", {31'b0, misalign}, {31'b0, mMisalign});
      if (expReq) checkOutput("imemAddr", imem_addr, mPc);
      if (expValid) begin
        checkOutput("pc", pc, mPc);
        checkOutput("opcode", {25'b0, opcode}, {25'b0, mInst[6:0]});
        checkOutput("func3", {29'b0, func3}, {29'b0, mInst[14:12]});
        checkOutput("func7", {25'b0, func7}, {25'b0, mInst[31:25]});
        checkOutput("rs1", {27'b0, rs1}, {27'b0, mInst[19:15]});
        checkOutput("rs2", {27'b0, rs2}, {27'b0, mInst[24:20]});
        checkOutput("rd", {27'b0, rd}, {27'b0, mInst[11:7]});
        checkOutput("imm", imm, refImm(mInst));
        checkOutput("ebreak", {31'b0, ebreak}, {31'b0, (mInst == 32'h0010_0073)});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for a request, stall it, accept it, delay the response, deliver it;
  // returns with the instruction being presented to the EXU
  task automatic applyStimulus(input logic [31:0] inst, input int reqDelay, input int rspDelay);
    int budget;
    budget = 0;
    while (!imem_req_valid && budget < 20) begin
      tick();
      budget++;
    end
    if (!imem_req_valid) checkOutput("reqTimeout", 32'd0, 32'd1);
    repeat (reqDelay) tick();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    repeat (rspDelay) tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = inst;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
  endtask

  // Hold the EXU back for a while, then accept with the given next PC
  task automatic retireInst(input int readyDelay, input logic [31:0] nextPc);
    repeat (readyDelay) tick();
    out_ready = 1'b1;
    pc_next   = nextPc;
    tick();
    out_ready = 1'b0;
    pc_next   = 32'h0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    compareOn = 1;
    tick();
    checkOutput("rstReqValid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("rstOutValid", {31'b0, out_valid}, 32'd0);
    checkOutput("rstHalted", {31'b0, halted}, 32'd0);
    checkOutput("rstMisalign", {31'b0, misalign}, 32'd0);
    rst = 1'b0;
    checkOutput("idleNoReq", {31'b0, imem_req_valid}, 32'd0);
    tick();
    checkOutput("firstReq", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("firstAddr", imem_addr, 32'h8000_0000);

    // addi x1,x0,-1 at minimum latency
    applyStimulus(32'hFFF0_0093, 0, 0);
    checkOutput("addiOpcode", {25'b0, opcode}, 32'h13);
    checkOutput("addiRd", {27'b0, rd}, 32'd1);
    checkOutput("addiRs1", {27'b0, rs1}, 32'd0);
    checkOutput("addiFunc3", {29'b0, func3}, 32'd0);
    checkOutput("addiImm", imm, 32'hFFFF_FFFF);
    retireInst(0, 32'h8000_0004);
    checkOutput("nextFetchAddr", imem_addr, 32'h8000_0004);
    checkOutput("nextFetchReq", {31'b0, imem_req_valid}, 32'd1);

    // sub x3,x1,x2 with 5 cycles of EXU backpressure
    applyStimulus(32'h4020_81B3, 0, 0);
    checkOutput("subFunc7", {25'b0, func7}, 32'h20);
    checkOutput("subRs2", {27'b0, rs2}, 32'd2);
    checkOutput("subImm", imm, 32'h0);
    retireInst(5, 32'h8000_0008);

    // sw x2,8(x1) with request and response stalls
    applyStimulus(32'h0020_A423, 3, 4);
    checkOutput("swImm", imm, 32'h0000_0008);
    checkOutput("swPc", pc, 32'h8000_0008);
    retireInst(0, 32'h8000_000C);

    // lui x5,0x12345
    applyStimulus(32'h1234_52B7, 1, 1);
    checkOutput("luiImm", imm, 32'h1234_5000);
    checkOutput("luiRd", {27'b0, rd}, 32'd5);
    retireInst(2, 32'h8000_0010);

    // Reset while waiting; the late response in IDLE and a stray one in
    // FETCH must both be dropped
    applyStimulus(32'h0000_0013, 0, 0);
    retireInst(0, 32'h8000_0014);
    tick();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0010_0073;
    tick();
    checkOutput("lateRspDrop", {31'b0, out_valid}, 32'd0);
    tick();
    imem_rsp_valid = 1'b0;
    checkOutput("postRstAddr", imem_addr, 32'h8000_0000);

    // jal x0,8 retired to a misaligned target
    applyStimulus(32'h0080_006F, 0, 2);
    checkOutput("jalImm", imm, 32'h0000_0008);
    retireInst(0, 32'h8000_0006);
    checkOutput("misHalted", {31'b0, halted}, 32'd1);
    checkOutput("misFlag", {31'b0, misalign}, 32'd1);
    checkOutput("misPc", pc, 32'h8000_0000);
    repeat (4) tick();

    // beq then ebreak
    doReset();
    applyStimulus(32'hFE00_0EE3, 0, 0);
    checkOutput("beqImm", imm, 32'hFFFF_FFFC);
    retireInst(0, 32'h8000_0004);
    applyStimulus(32'h0010_0073, 0, 1);
    checkOutput("ebreakFlag", {31'b0, ebreak}, 32'd1);
    retireInst(1, 32'h8000_0100);
    checkOutput("ebHalted", {31'b0, halted}, 32'd1);
    checkOutput("ebMisalign", {31'b0, misalign}, 32'd0);
    checkOutput("ebPc", pc, 32'h8000_0004);
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    repeat (5) tick();
    checkOutput("ebNoReq", {31'b0, imem_req_valid}, 32'd0);
    imem_req_ready = 1'b0;
    out_ready      = 1'b0;

    compareOn = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
